// File: rtl/cmp_error_evaluator_pkg.sv
// Shared types and helpers for the comparator error evaluator.
package cmp_eval_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Error counters need one bit beyond the operand-pair index so that a
  // DUT that gets every pair wrong (2^(2W) errors) still fits without wrap.
  function automatic int cnt_width(input int width);
    return 2 * width + 1;
  endfunction

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

  // Exact comparison result for one operand pair
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } golden_t;

endpackage

// File: rtl/cmp_error_evaluator_if.sv
// Harness-side bundle: sweep control/status, DUT operand/response bus and
// the error counters. master = the evaluator, slave = the harness around it.
interface cmp_eval_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = cmp_eval_pkg::cnt_width(WIDTH);

  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_eq;
  logic             dut_gt;
  logic             dut_lt;
  logic [CNT_W-1:0] eq_err;
  logic [CNT_W-1:0] gt_err;
  logic [CNT_W-1:0] lt_err;
  logic [CNT_W-1:0] pair_err;

  modport master (
    input  start, dut_eq, dut_gt, dut_lt,
    output busy, done, dut_a, dut_b, eq_err, gt_err, lt_err, pair_err
  );

  modport slave (
    output start, dut_eq, dut_gt, dut_lt,
    input  busy, done, dut_a, dut_b, eq_err, gt_err, lt_err, pair_err
  );

endinterface

// File: rtl/cmp_error_evaluator_golden_delay.sv
// Delay line that carries {valid, golden result} alongside the DUT pipeline
// so each DUT response is compared against the pair that produced it.
// LATENCY = 0 degenerates to a wire.
module cmp_golden_delay
  import cmp_eval_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    vld_i,
  input  golden_t gold_i,
  output logic    vld_o,
  output golden_t gold_o
);

  if (LATENCY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign vld_o  = vld_i;
    assign gold_o = gold_i;
  end else begin : g_dly
    logic [LATENCY-1:0] vld_q;
    golden_t            gold_q [LATENCY];

    // Valid bits are control: cleared on reset so stale entries never compare
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= vld_i;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Golden payload is qualified by its valid bit, so it needs no reset
    always_ff @(posedge clk) begin
      gold_q[0] <= gold_i;
      for (int i = 1; i < LATENCY; i++) begin
        gold_q[i] <= gold_q[i-1];
      end
    end

    assign vld_o  = vld_q[LATENCY-1];
    assign gold_o = gold_q[LATENCY-1];
  end

endmodule

// File: rtl/cmp_error_evaluator.sv
// Exhaustive characterisation engine for a comparator under test: sweeps
// every (A,B) pair, compares EQ/GT/LT against the exact result and counts
// per-flag and per-pair errors.
module cmp_error_evaluator
  import cmp_eval_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0
) (
  input  logic          clk,
  input  logic          rst,
  cmp_eval_if.master    bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int IDX_W = 2 * WIDTH;
  localparam int DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DRN_W-1:0]   drain_q;
  logic               busy_q;
  logic               done_q;

  logic [CNT_W-1:0]   eq_err_q,   eq_err_d;
  logic [CNT_W-1:0]   gt_err_q,   gt_err_d;
  logic [CNT_W-1:0]   lt_err_q,   lt_err_d;
  logic [CNT_W-1:0]   pair_err_q, pair_err_d;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  golden_t            gold_now;
  logic               push_vld;
  logic               cmp_vld;
  golden_t            cmp_gold;
  logic               start_ok;
  logic               err_eq, err_gt, err_lt;

  // Operands come straight from the index; idx sits at 0 outside SWEEP
  assign op_a = idx_q[IDX_W-1:WIDTH];
  assign op_b = idx_q[WIDTH-1:0];

  assign gold_now.eq = (op_a == op_b);
  assign gold_now.gt = (op_a >  op_b);
  assign gold_now.lt = (op_a <  op_b);

  assign push_vld = (state_q == SWEEP);
  assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));

  cmp_golden_delay #(
    .LATENCY (LATENCY)
  ) u_golden_delay (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (push_vld),
    .gold_i (gold_now),
    .vld_o  (cmp_vld),
    .gold_o (cmp_gold)
  );

  // Sweep controller with registered busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        SWEEP: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == {IDX_W{1'b1}}) begin
            if (LATENCY > 0) begin
              state_q <= DRAIN;
              drain_q <= DRAIN_LOAD;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign err_eq = bus.dut_eq ^ cmp_gold.eq;
  assign err_gt = bus.dut_gt ^ cmp_gold.gt;
  assign err_lt = bus.dut_lt ^ cmp_gold.lt;

  // Next counter values: clear on an accepted start, else count mismatches
  always_comb begin
    eq_err_d   = eq_err_q;
    gt_err_d   = gt_err_q;
    lt_err_d   = lt_err_q;
    pair_err_d = pair_err_q;
    if (start_ok) begin
      eq_err_d   = '0;
      gt_err_d   = '0;
      lt_err_d   = '0;
      pair_err_d = '0;
    end else if (cmp_vld) begin
      eq_err_d   = eq_err_q   + CNT_W'(err_eq);
      gt_err_d   = gt_err_q   + CNT_W'(err_gt);
      lt_err_d   = lt_err_q   + CNT_W'(err_lt);
      pair_err_d = pair_err_q + CNT_W'(err_eq | err_gt | err_lt);
    end
  end

  // Error counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_err_q   <= '0;
      gt_err_q   <= '0;
      lt_err_q   <= '0;
      pair_err_q <= '0;
    end else begin
      eq_err_q   <= eq_err_d;
      gt_err_q   <= gt_err_d;
      lt_err_q   <= lt_err_d;
      pair_err_q <= pair_err_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dut_a    = op_a;
  assign bus.dut_b    = op_b;
  assign bus.eq_err   = eq_err_q;
  assign bus.gt_err   = gt_err_q;
  assign bus.lt_err   = lt_err_q;
  assign bus.pair_err = pair_err_q;

endmodule

// File: tb/tb_cmp_error_evaluator.sv
// Bench for cmp_error_evaluator: one combinational-DUT instance (LATENCY=0)
// and one pipelined-DUT instance (LATENCY=2), each fed by a comparator model
// with selectable faults. Expected counts are queued at start, checked at done.
module tb_cmp_error_evaluator;

  logic clk;
  logic rst;

  cmp_eval_if #(.WIDTH(4)) bus0 ();
  cmp_eval_if #(.WIDTH(4)) bus2 ();

  cmp_error_evaluator #(.WIDTH(4), .LATENCY(0)) u_eval0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  cmp_error_evaluator #(.WIDTH(4), .LATENCY(2)) u_eval2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Comparator models. mode0: 0 exact, 1 tied low, 2 GT/LT swapped.
  // mode2: 0 exact registered twice, 1 exact registered once.
  int mode0 = 0;
  int mode2 = 0;

  always_comb begin
    bus0.dut_eq = (bus0.dut_a == bus0.dut_b);
    bus0.dut_gt = (bus0.dut_a >  bus0.dut_b);
    bus0.dut_lt = (bus0.dut_a <  bus0.dut_b);
    if (mode0 == 1) begin
      bus0.dut_eq = 1'b0;
      bus0.dut_gt = 1'b0;
      bus0.dut_lt = 1'b0;
    end else if (mode0 == 2) begin
      bus0.dut_gt = (bus0.dut_a < bus0.dut_b);
      bus0.dut_lt = (bus0.dut_a > bus0.dut_b);
    end
  end

  logic [2:0] r1_q, r2_q;
  always @(posedge clk) begin
    r1_q <= {bus2.dut_a == bus2.dut_b, bus2.dut_a > bus2.dut_b, bus2.dut_a < bus2.dut_b};
    r2_q <= r1_q;
  end
  assign {bus2.dut_eq, bus2.dut_gt, bus2.dut_lt} = (mode2 == 1) ? r1_q : r2_q;

  // Busy-length and busy/done overlap monitors
  int busy_cnt0 = 0;
  int busy_cnt2 = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    if (bus0.busy === 1'b1) busy_cnt0++;
    if (bus2.busy === 1'b1) busy_cnt2++;
    if ((bus0.busy && bus0.done) || (bus2.busy && bus2.done)) overlap_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    string tag;
    int    eq;
    int    gt;
    int    lt;
    int    pair;
    int    busy;
  } exp_t;

  exp_t sb_q[$];

  // Reference: walk all 256 pairs, apply the fault model, count flag errors
  function automatic void model_counts(input int sel, input int mode,
                                       output int e_eq, output int e_gt,
                                       output int e_lt, output int e_pair);
    int a, b, oa, ob, kk;
    bit g_eq, g_gt, g_lt, o_eq, o_gt, o_lt;
    e_eq = 0; e_gt = 0; e_lt = 0; e_pair = 0;
    for (int k = 0; k < 256; k++) begin
      a = k / 16;
      b = k % 16;
      g_eq = (a == b); g_gt = (a > b); g_lt = (a < b);
      if (sel == 0) begin
        o_eq = g_eq; o_gt = g_gt; o_lt = g_lt;
        if (mode == 1) begin
          o_eq = 1'b0; o_gt = 1'b0; o_lt = 1'b0;
        end else if (mode == 2) begin
          o_gt = g_lt; o_lt = g_gt;
        end
      end else begin
        // one-cycle-early DUT shows the next pair; after the last pair the
        // operands have returned to (0,0)
        kk = (mode == 1) ? ((k == 255) ? 0 : k + 1) : k;
        oa = kk / 16;
        ob = kk % 16;
        o_eq = (oa == ob); o_gt = (oa > ob); o_lt = (oa < ob);
      end
      if (o_eq != g_eq) e_eq++;
      if (o_gt != g_gt) e_gt++;
      if (o_lt != g_lt) e_lt++;
      if ((o_eq != g_eq) || (o_gt != g_gt) || (o_lt != g_lt)) e_pair++;
    end
  endfunction

  task automatic do_sweep(input int sel, input int mode, input string tag, input bit disturb);
    exp_t e;
    int   base;
    bit   seen;
    logic [31:0] o_eq, o_gt, o_lt, o_pair, o_done, o_busy;
    e.tag  = tag;
    model_counts(sel, mode, e.eq, e.gt, e.lt, e.pair);
    e.busy = 256 + ((sel == 0) ? 0 : 2);
    sb_q.push_back(e);

    if (sel == 0) mode0 = mode; else mode2 = mode;
    @(negedge clk);
    base = (sel == 0) ? busy_cnt0 : busy_cnt2;
    if (sel == 0) bus0.start = 1'b1; else bus2.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus2.start = 1'b0;

    seen = 1'b0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      if (sel == 0) begin
        if (bus0.start) bus0.start = 1'b0;
        if (disturb && bus0.busy && bus0.dut_a == 4'd3 && bus0.dut_b == 4'd2)
          bus0.start = 1'b1;
        if (bus0.done) seen = 1'b1;
      end else begin
        if (bus2.done) seen = 1'b1;
      end
      if (!seen) @(negedge clk);
    end
    bus0.start = 1'b0;

    e = sb_q.pop_front();
    check_val({e.tag, "_timeout"}, 32'(seen), 32'd1);
    if (sel == 0) begin
      o_eq = 32'(bus0.eq_err); o_gt = 32'(bus0.gt_err);
      o_lt = 32'(bus0.lt_err); o_pair = 32'(bus0.pair_err);
      o_done = 32'(bus0.done); o_busy = 32'(busy_cnt0 - base);
    end else begin
      o_eq = 32'(bus2.eq_err); o_gt = 32'(bus2.gt_err);
      o_lt = 32'(bus2.lt_err); o_pair = 32'(bus2.pair_err);
      o_done = 32'(bus2.done); o_busy = 32'(busy_cnt2 - base);
    end
    check_val({e.tag, "_eq_err"},   o_eq,   e.eq);
    check_val({e.tag, "_gt_err"},   o_gt,   e.gt);
    check_val({e.tag, "_lt_err"},   o_lt,   e.lt);
    check_val({e.tag, "_pair_err"}, o_pair, e.pair);
    check_val({e.tag, "_done"},     o_done, 32'd1);
    check_val({e.tag, "_busy_len"}, o_busy, e.busy);
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    bus0.start = 1'b0;
    bus2.start = 1'b0;
    #12;
    check_val("rst_busy",     32'(bus0.busy),     32'd0);
    check_val("rst_done",     32'(bus0.done),     32'd0);
    check_val("rst_dut_a",    32'(bus0.dut_a),    32'd0);
    check_val("rst_dut_b",    32'(bus0.dut_b),    32'd0);
    check_val("rst_pair_err", 32'(bus0.pair_err), 32'd0);
    check_val("rst_busy2",    32'(bus2.busy),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    do_sweep(0, 0, "exact_l0",   1'b0);
    do_sweep(0, 1, "tied_l0",    1'b0);
    do_sweep(0, 2, "swap_l0",    1'b0);
    do_sweep(2, 0, "exact_l2",   1'b0);
    do_sweep(2, 1, "short_l2",   1'b0);
    check_val("short_l2_nonzero", 32'(bus2.pair_err != 0), 32'd1);
    do_sweep(0, 1, "midstart_l0", 1'b1);

    // Reset in the middle of a sweep at idx = 100 (A=6, B=4)
    mode0 = 1;
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      if (bus0.dut_a == 4'd6 && bus0.dut_b == 4'd4) hit = 1'b1;
      else @(negedge clk);
    end
    check_val("midrst_reached", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_busy",     32'(bus0.busy),     32'd0);
    check_val("midrst_done",     32'(bus0.done),     32'd0);
    check_val("midrst_dut_a",    32'(bus0.dut_a),    32'd0);
    check_val("midrst_dut_b",    32'(bus0.dut_b),    32'd0);
    check_val("midrst_pair_err", 32'(bus0.pair_err), 32'd0);
    check_val("midrst_eq_err",   32'(bus0.eq_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_sweep(0, 1, "after_rst_l0", 1'b0);

    check_val("busy_done_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmp_error_evaluator.md
Name: cmp_error_evaluator

Overview:
Sequential characterisation engine for the comparator family. It drives an exhaustive sweep of every (A,B) operand pair into an external comparator under test (DUT). It then captures the DUT's EQ/GT/LT responses and compares each against an exact golden result. It accumulates per-flag and per-pair error counts, and sits beside any comparator variant in the evaluation harness.

Parameters:
- WIDTH, 4, operand width of the comparator under test.
- LATENCY, 0, DUT pipeline depth in cycles: 0 = combinational DUT, N = outputs valid N cycles after operands.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begin a sweep; sampled only in IDLE or DONE.
- busy, output, 1, high during SWEEP and DRAIN.
- done, output, 1, high in DONE until next start.
- dut_a, output, WIDTH, operand A to the DUT.
- dut_b, output, WIDTH, operand B to the DUT.
- dut_eq, input, 1, DUT EQ response.
- dut_gt, input, 1, DUT GT response.
- dut_lt, input, 1, DUT LT response.
- eq_err, output, 2*WIDTH+1, count of pairs with a wrong EQ.
- gt_err, output, 2*WIDTH+1, count of pairs with a wrong GT.
- lt_err, output, 2*WIDTH+1, count of pairs with a wrong LT.
- pair_err, output, 2*WIDTH+1, count of pairs with any flag wrong.

Behaviour:
- Reset (async, any state):
  - FSM to IDLE; idx = 0; delay line valid bits = 0.
  - All counters = 0; busy = 0; done = 0; dut_a = dut_b = 0.
  - Reset mid-sweep discards all partial results.
- Golden reference is exact: eq = (a==b), gt = (a>b), lt = (a<b), unsigned.
- Operand mapping: idx is 2*WIDTH bits; dut_a = idx[2W-1:W]; dut_b = idx[W-1:0]. Both are driven directly from the idx register. In IDLE, DONE and DRAIN they hold 0.
- FSM states:
  - IDLE: start=1 → clear all counters, idx = 0, go to SWEEP.
  - SWEEP: idx increments every cycle. When idx = all-ones is presented: go to DRAIN if LATENCY > 0, else to DONE. idx wraps to 0.
  - DRAIN: count down LATENCY cycles, then go to DONE.
  - DONE: done = 1; counters hold. start=1 → clear counters and go to SWEEP, as from IDLE.
- Sweep length: exactly 2^(2*WIDTH) pairs; busy is high for 2^(2*WIDTH) + LATENCY cycles.
- Alignment:
  - Each SWEEP cycle pushes {valid=1, golden eq/gt/lt} into a LATENCY-deep shift register.
  - LATENCY = 0: DUT responses are compared in the same cycle.
  - LATENCY > 0: the compare fires when the delayed entry's valid bit is high. DRAIN pushes valid=0.
- Counter update on the clock edge after each valid compare:
  - each *_err increments by 1 when its DUT flag differs from golden;
  - pair_err increments once if any flag differs.
- Counter width 2*WIDTH+1 holds the maximum 2^(2W) without saturation, so no wrap is possible.
- start while busy is ignored; there is no restart and no counter clear.
- done and busy are never high together.
- Simultaneous start and rst: rst wins.

Decomposition:
- Shared package cmp_eval_pkg holds:
  - the FSM state enum {IDLE, SWEEP, DRAIN, DONE};
  - the constant for counter width, 2*WIDTH+1;
  - a golden-result struct {eq, gt, lt}.
- One sub-module, cmp_golden_delay: the LATENCY-deep valid + golden shift register, with a pass-through when LATENCY = 0.

Test Plan:
- Exact combinational comparator DUT, WIDTH=4, LATENCY=0 → after 256 busy cycles done=1; eq_err = gt_err = lt_err = pair_err = 0.
- DUT tied eq=gt=lt=0, WIDTH=4 → eq_err=16, gt_err=120, lt_err=120, pair_err=256.
- DUT with GT and LT outputs swapped → eq_err=0, gt_err=120, lt_err=120, pair_err=240.
- Exact DUT registered twice, LATENCY=2 → all counts 0; busy high for exactly 258 cycles. Setting the DUT's real latency to 1 against LATENCY=2 → pair_err nonzero.
- Pulse start at idx=50 mid-sweep → ignored; totals are identical to an undisturbed run.
- Assert rst at idx=100 → immediately IDLE, all counts 0, busy=0, dut_a=dut_b=0. A new start then gives a full correct sweep.
